if_id_skid_reg: RTL and testbench
=================================

# if_id_skid_reg

Parametrised IF→ID pipeline register with a valid/ready handshake and a two-entry skid buffer, the successor to the plain hold-enabled fetch/decode flop pair. It carries instruction and instruction address from fetch to decode. It sustains full throughput under back-pressure with no combinational path from `out_ready` to `in_ready`. It supports a pipeline flush that drops all buffered beats, and it presents a NOP to decode whenever no valid instruction is held.

## Interface

Parameters:
- `INST_W`, 32, instruction width.
- `ADDR_W`, 32, instruction address width.
- `NOP_INST`, `32'h00000013`, instruction presented when the output is invalid (truncated/zero-extended to `INST_W`).
- `RST_ADDR`, 0, address register reset value.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `flush`  in  1  discard all held and incoming beats.
- `in_valid`  in  1  fetch offers a beat.
- `in_ready`  out  1  block can accept a beat; a function of registered state only.
- `in_inst`  in  `INST_W`  instruction from fetch.
- `in_addr`  in  `ADDR_W`  address from fetch.
- `out_valid`  out  1  decode beat valid.
- `out_ready`  in  1  decode accepts the beat.
- `out_inst`  out  `INST_W`  instruction to decode; equals `NOP_INST` when `out_valid=0`.
- `out_addr`  out  `ADDR_W`  address of the main entry.
- `occupancy`  out  2  number of held beats (0..2).

## Operation

- Storage:
  - Main entry (`main_inst`, `main_addr`) drives the outputs.
  - Skid entry (`skid_inst`, `skid_addr`) holds a second beat.
- Handshake terms: `push = in_valid & in_ready`; `pop = out_valid & out_ready`.
- State machine EMPTY / ONE / FULL; `occupancy` = 0/1/2.
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL).
- Transitions, when `flush=0`:
  - EMPTY, push: main←in, go to ONE. No push: stay in EMPTY.
  - ONE, push and pop: main←in, stay in ONE.
  - ONE, push and no pop: skid←in, go to FULL.
  - ONE, pop and no push: go to EMPTY.
  - ONE, neither: hold.
  - FULL, pop: main←skid, go to ONE. No pop: hold. Push is impossible because `in_ready=0`.
- Ordering: beats leave in acceptance order. Nothing is dropped or duplicated except on flush.
- `flush=1`:
  - Next state is EMPTY regardless of push or pop.
  - A beat pushed in the same cycle counts as consumed by fetch and is discarded.
  - A pop in the same cycle completes normally from decode's view.
  - Data registers are not cleared. `out_inst` shows NOP through masking; `out_addr` keeps its last value.
- `out_inst` = `out_valid ? main_inst : NOP_INST`, a combinational mask on registered state.
- Data registers load only on the events above, with no enable otherwise, to minimise toggling.

## Timing

- Reset, asynchronous, takes effect immediately:
  - State is EMPTY, so `out_valid=0`, `in_ready=1`, `occupancy=0`.
  - `out_inst=NOP_INST`.
  - `main_addr=skid_addr=RST_ADDR`.
  - `main_inst=skid_inst=NOP_INST`.
- Latency: a beat pushed at edge N is visible on `out_*` with `out_valid=1` after edge N.
- Throughput: one beat per cycle while `out_ready=1`.
- Back-pressure:
  - The first stalled cycle absorbs one extra beat into skid.
  - `in_ready` falls the cycle after the skid fills.
  - `in_ready` rises the cycle after the first pop from FULL.
- `in_ready`, `out_valid` and `occupancy` are driven from flops; there are no combinational input→output paths on control.
- Reset asserted mid-operation: all beats are lost immediately. After deassertion the first push is accepted on the next edge.

## Test plan

- Reset: assert `rst` while FULL, between clock edges.
  - Outputs go immediately to `out_valid=0`, `in_ready=1`, `occupancy=0`, `out_inst=0x00000013`, `out_addr=RST_ADDR`.
- Streaming: push addresses 0x100, 0x104, … for 8 cycles with `out_ready=1`.
  - `out_addr` follows one cycle later, one beat per cycle, `occupancy=1` throughout.
- Back-pressure: with `out_ready=0`, push A (0x200) then B (0x204) in consecutive cycles.
  - `occupancy` reads 1, then 2; `in_ready=0`; C is held off.
  - Raise `out_ready`: A, then B, then C emerge in order, with `in_ready=1` again one cycle after the first pop.
- Flush while FULL, together with an offered beat:
  - Next cycle shows `occupancy=0`, `out_valid=0`, `out_inst=NOP_INST`.
  - The flushed beat never appears.
  - A beat at 0x300 pushed afterwards appears alone.
- Flush with simultaneous push and pop in state ONE:
  - The popped beat is counted once at decode; the pushed beat is discarded.
  - State is EMPTY next cycle.
- Random stress: random `in_valid`, `out_ready` and rare `flush` over 10k cycles.
  - A scoreboard sees in-order, loss-free delivery between flushes.
  - `out_inst==NOP_INST` whenever `out_valid=0`.
  - `in_ready` never depends on same-cycle `out_ready`.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF->ID pipeline register with valid/ready handshake and a two-entry skid buffer.
// Control outputs come straight from the state flop, so out_ready never reaches in_ready.
module if_id_skid_reg #(
  parameter int                 INST_W   = 32,
  parameter int                 ADDR_W   = 32,
  parameter logic [31:0]        NOP_INST = 32'h00000013,
  parameter logic [ADDR_W-1:0]  RST_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        occupancy
);

  localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } beat_t;

  logic [1:0] state, state_nxt;
  beat_t      main_q, skid_q, in_beat;
  logic       push, pop;
  logic       main_ld, main_from_skid, skid_ld;

  assign in_beat   = '{inst: in_inst, addr: in_addr};
  assign out_valid = (state != S_EMPTY);
  assign in_ready  = (state != S_FULL);
  assign occupancy = state;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_inst  = out_valid ? main_q.inst : NOP_W;
  assign out_addr  = main_q.addr;

  always_comb begin
    state_nxt      = state;
    main_ld        = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state)
      S_EMPTY: begin
        if (push) begin
          main_ld   = 1'b1;
          state_nxt = S_ONE;
        end
      end
      S_ONE: begin
        if (push && pop) begin
          main_ld   = 1'b1;
        end else if (push) begin
          skid_ld   = 1'b1;
          state_nxt = S_FULL;
        end else if (pop) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (pop) begin
          main_ld        = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = S_ONE;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
    // Flush drops everything; data flops keep their contents and out_inst is masked.
    if (flush) begin
      state_nxt = S_EMPTY;
      main_ld   = 1'b0;
      skid_ld   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '{inst: NOP_W, addr: RST_ADDR};
    end else if (main_ld) begin
      main_q <= main_from_skid ? skid_q : in_beat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_q <= '{inst: NOP_W, addr: RST_ADDR};
    end else if (skid_ld) begin
      skid_q <= in_beat;
    end
  end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: a queue model of held beats, checked every negedge.
module tb_if_id_skid_reg;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic [1:0]  occupancy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] addr;
  } beat_t;

  beat_t q[$];

  if_id_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two accepted beats.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
    end else if (flush) begin
      q.delete();
    end else if (in_valid && q.size() < 2) begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      q.push_back('{inst: in_inst, addr: in_addr});
    end else if (q.size() > 0 && out_ready) begin
      void'(q.pop_front());
    end
  end

  // Monitor: compares DUT outputs with the model front away from the active edge.
  always @(negedge clk) begin
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("occupancy", {62'd0, occupancy}, 64'(q.size()));
    chk("out_inst", {32'd0, out_inst}, {32'd0, (q.size() > 0) ? q[0].inst : NOP});
    if (q.size() > 0) chk("out_addr", {32'd0, out_addr}, {32'd0, q[0].addr});
  end

  // Inputs change 1 time unit after the rising edge, then one clock elapses.
  task automatic step(input bit iv, input logic [31:0] ii, input logic [31:0] ia,
                      input bit ordy, input bit fl);
    in_valid  = iv;
    in_inst   = ii;
    in_addr   = ia;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Fill to FULL, then assert reset between edges.
    step(1, 32'hA0, 32'h10, 0, 0);
    step(1, 32'hA1, 32'h14, 0, 0);
    chk("full_occ", {62'd0, occupancy}, 64'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_occ", {62'd0, occupancy}, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, {32'd0, NOP});
    chk("rst_out_addr", {32'd0, out_addr}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming at full rate.
    for (int i = 0; i < 8; i++) begin
      step(1, 32'h1000 + 32'(i), 32'h100 + 32'(4 * i), 1, 0);
      chk("stream_occ", {62'd0, occupancy}, 64'd1);
      chk("stream_addr", {32'd0, out_addr}, {32'd0, 32'h100 + 32'(4 * i)});
    end
    step(0, 0, 0, 1, 0);
    chk("stream_drain", {63'd0, out_valid}, 64'd0);

    // Back-pressure: A, B absorbed, C held off until a pop frees the skid.
    step(1, 32'hA, 32'h200, 0, 0);
    chk("bp_occ1", {62'd0, occupancy}, 64'd1);
    step(1, 32'hB, 32'h204, 0, 0);
    chk("bp_occ2", {62'd0, occupancy}, 64'd2);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_no_comb", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b0;
    step(1, 32'hC, 32'h208, 1, 0);
    chk("bp_addr_B", {32'd0, out_addr}, 64'h204);
    chk("bp_in_ready_back", {63'd0, in_ready}, 64'd1);
    step(1, 32'hC, 32'h208, 1, 0);
    chk("bp_addr_C", {32'd0, out_addr}, 64'h208);
    step(0, 0, 0, 1, 0);
    chk("bp_empty", {62'd0, occupancy}, 64'd0);

    // Flush while FULL with an offered beat.
    step(1, 32'hD0, 32'h2F0, 0, 0);
    step(1, 32'hD1, 32'h2F4, 0, 0);
    step(1, 32'hDEAD, 32'h2F8, 0, 1);
    chk("fl_occ", {62'd0, occupancy}, 64'd0);
    chk("fl_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_inst", {32'd0, out_inst}, {32'd0, NOP});
    step(1, 32'h300, 32'h300, 0, 0);
    chk("fl_after_occ", {62'd0, occupancy}, 64'd1);
    chk("fl_after_addr", {32'd0, out_addr}, 64'h300);
    step(0, 0, 0, 1, 0);
    chk("fl_after_empty", {62'd0, occupancy}, 64'd0);

    // Flush in ONE with simultaneous push and pop.
    step(1, 32'hE0, 32'h400, 0, 0);
    step(1, 32'hE1, 32'h404, 1, 1);
    chk("fl1_occ", {62'd0, occupancy}, 64'd0);
    chk("fl1_inst", {32'd0, out_inst}, {32'd0, NOP});

    // Random stress.
    for (int i = 0; i < 10000; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom,
           $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("final_empty", {62'd0, occupancy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
